// File: rtl/clk_monitor.sv
// clk_monitor: measures the period and high time of an asynchronous
// clock-like signal (Mon_In) in units of Clk cycles. It flags out-of-range
// periods and detects a stuck (edge-free) input.
//
// Optional feature: define CLK_MON_DUTY_EN to enable high-time measurement
// and the duty sanity check. When it is undefined, High_Cnt is tied to 0.
//
// Ports:
//   Clk       in   system clock, all logic on its rising edge
//   Rst       in   synchronous active-high reset
//   Mon_In    in   monitored signal, asynchronous to Clk
//   Clr       in   single-cycle clear of the sticky Prd_Err flag
//   Prd_Valid out  one-cycle pulse, a new measurement is on Prd_Cnt/High_Cnt
//   Prd_Cnt   out  last measured period (Clk cycles)
//   High_Cnt  out  last measured high time (Clk cycles)
//   Locked    out  at least one full period has been measured
//   Stuck     out  no Mon_In edge seen for STUCK_LIM cycles
//   Prd_Err   out  sticky out-of-range flag
module clk_monitor #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MIN_PRD   = 4,
  parameter int unsigned MAX_PRD   = 64,
  parameter int unsigned STUCK_LIM = 256
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Mon_In,
  input  logic             Clr,
  output logic             Prd_Valid,
  output logic [CNT_W-1:0] Prd_Cnt,
  output logic [CNT_W-1:0] High_Cnt,
  output logic             Locked,
  output logic             Stuck,
  output logic             Prd_Err
);

  localparam int unsigned IDLE_W = $clog2(STUCK_LIM + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(STUCK_LIM);

  typedef enum logic [1:0] {IDLE, ARMED, LOCK} state_t;

  state_t            state, state_nxt;
  logic              s1, s2, s3;
  logic              rise, fall;
  logic [CNT_W-1:0]  cnt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic              timeout;
  logic              meas;
  logic              bad;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= Mon_In;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Period counter; saturates so a very long period stays out of range.
  always_ff @(posedge Clk) begin
    if (Rst)                 cnt <= '0;
    else if (rise)           cnt <= CNT_W'(1);
    else if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
  end

  // Edge-free cycle counter, saturating at STUCK_LIM.
  always_comb begin
    idle_nxt = idle_cnt;
    if (rise | fall)              idle_nxt = '0;
    else if (idle_cnt != IDLE_LIM) idle_nxt = idle_cnt + IDLE_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst) idle_cnt <= '0;
    else     idle_cnt <= idle_nxt;
  end

  // Stuck and the drop to IDLE appear on the same edge.
  assign timeout = (idle_nxt == IDLE_LIM);
  assign Stuck   = (idle_cnt == IDLE_LIM);

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = ARMED;
      ARMED:   if (rise) state_nxt = LOCK;
      LOCK:    state_nxt = LOCK;
      default: state_nxt = IDLE;
    endcase
    if (timeout) state_nxt = IDLE;
  end

  // FSM: outputs
  always_comb begin
    Locked = (state == LOCK);
    meas   = rise && (state != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      Prd_Valid <= 1'b0;
      Prd_Cnt   <= '0;
    end else begin
      Prd_Valid <= meas;
      if (meas) Prd_Cnt <= cnt;
    end
  end

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] hcnt;

  // High-time counter: counts while the synchronised input is high,
  // holds while low so the value is still valid at the next rise.
  always_ff @(posedge Clk) begin
    if (Rst)                        hcnt <= '0;
    else if (rise)                  hcnt <= CNT_W'(1);
    else if (s2 && hcnt != CNT_MAX) hcnt <= hcnt + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Rst)       High_Cnt <= '0;
    else if (meas) High_Cnt <= hcnt;
  end

  assign bad = Prd_Valid && ((Prd_Cnt < CNT_W'(MIN_PRD)) || (Prd_Cnt > CNT_W'(MAX_PRD)) ||
                             (Prd_Cnt == CNT_MAX) || (High_Cnt == '0) ||
                             (High_Cnt == Prd_Cnt));
`else
  assign High_Cnt = '0;

  assign bad = Prd_Valid && ((Prd_Cnt < CNT_W'(MIN_PRD)) || (Prd_Cnt > CNT_W'(MAX_PRD)) ||
                             (Prd_Cnt == CNT_MAX));
`endif

  // Error is judged on the registered measurement, one cycle after
  // Prd_Valid, so a Clr during the Prd_Valid cycle loses to the set.
  always_ff @(posedge Clk) begin
    if (Rst)      Prd_Err <= 1'b0;
    else if (bad) Prd_Err <= 1'b1;
    else if (Clr) Prd_Err <= 1'b0;
  end

endmodule

// File: tb/tb_clk_monitor.sv
module tb_clk_monitor;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned MIN_PRD   = 4;
  localparam int unsigned MAX_PRD   = 64;
  localparam int unsigned STUCK_LIM = 256;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             Mon_In;
  logic             Clr;
  logic             Prd_Valid;
  logic [CNT_W-1:0] Prd_Cnt;
  logic [CNT_W-1:0] High_Cnt;
  logic             Locked;
  logic             Stuck;
  logic             Prd_Err;

  clk_monitor #(
    .CNT_W(CNT_W), .MIN_PRD(MIN_PRD), .MAX_PRD(MAX_PRD), .STUCK_LIM(STUCK_LIM)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Mon_In(Mon_In), .Clr(Clr),
    .Prd_Valid(Prd_Valid), .Prd_Cnt(Prd_Cnt), .High_Cnt(High_Cnt),
    .Locked(Locked), .Stuck(Stuck), .Prd_Err(Prd_Err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int exp_cyc;
    int prd;
    int high;
    bit err;
  } meas_t;

  meas_t sbq[$];

  // Reference model: works on the sample index (Clk edge number) at which
  // each level change of Mon_In is first captured.
  bit mlvl       = 1'b0;
  bit marmed     = 1'b0;
  bit merr       = 1'b0;
  int mlast_chg  = 0;
  int mlast_rise = 0;
  int mhigh      = 0;
  int clr_at     = -1;
  bit clr_on_bad = 1'b0;

  int pend_cyc = -1;
  bit pend_err = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_cycle(input bit lvl);
    meas_t m;
    int    idx;
    bit    bad;
    @(negedge Clk);
    Mon_In = lvl;
    Clr    = (cyc == clr_at);
    idx    = cyc + 1;
    if (lvl != mlvl) begin
      if (idx - mlast_chg > int'(STUCK_LIM)) marmed = 1'b0;
      mlast_chg = idx;
      if (lvl) begin
        if (marmed) begin
          m.prd = idx - mlast_rise;
          bad   = (m.prd < int'(MIN_PRD)) || (m.prd > int'(MAX_PRD));
`ifdef CLK_MON_DUTY_EN
          m.high = mhigh;
          bad    = bad || (mhigh == 0) || (mhigh == m.prd);
`else
          m.high = 0;
`endif
          merr      = merr | bad;
          m.err     = merr;
          m.exp_cyc = idx + 2;
          sbq.push_back(m);
          if (bad && clr_on_bad) begin
            clr_at     = idx + 2;
            clr_on_bad = 1'b0;
          end
        end
        marmed     = 1'b1;
        mlast_rise = idx;
      end else begin
        mhigh = idx - mlast_rise;
      end
      mlvl = lvl;
    end
  endtask

  task automatic seg(input bit lvl, input int len);
    for (int i = 0; i < len; i++) drive_cycle(lvl);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && sbq.size() > 0; i++) @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    check("queue_drained", sbq.size(), 0);
  endtask

  task automatic do_clr();
    @(negedge Clk);
    Clr  = 1'b1;
    merr = 1'b0;
    @(negedge Clk);
    Clr = 1'b0;
    check("prd_err_after_clr", Prd_Err, merr);
  endtask

  task automatic reset_dut(input int ncyc);
    @(negedge Clk);
    Rst    = 1'b1;
    Mon_In = 1'b0;
    Clr    = 1'b0;
    for (int i = 0; i < ncyc; i++) @(negedge Clk);
    check("rst_prd_valid", Prd_Valid, 0);
    check("rst_prd_cnt",   Prd_Cnt,   0);
    check("rst_high_cnt",  High_Cnt,  0);
    check("rst_locked",    Locked,    0);
    check("rst_stuck",     Stuck,     0);
    check("rst_prd_err",   Prd_Err,   0);
    Rst       = 1'b0;
    mlvl      = 1'b0;
    marmed    = 1'b0;
    merr      = 1'b0;
    mlast_chg = cyc - 2;
    pend_cyc  = -1;
  endtask

  // Monitor: compares every Prd_Valid against the scoreboard, and the
  // sticky error one cycle later.
  always @(negedge Clk) begin
    meas_t m;
    if (!Rst) begin
      if (pend_cyc == cyc) begin
        check("prd_err", Prd_Err, pend_err);
        pend_cyc = -1;
      end
      while (sbq.size() > 0 && sbq[0].exp_cyc < cyc) begin
        check("valid_missing", 0, 1);
        void'(sbq.pop_front());
      end
      if (Prd_Valid) begin
        if (sbq.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          m = sbq.pop_front();
          check("valid_cycle", cyc, m.exp_cyc);
          check("prd_cnt", Prd_Cnt, m.prd);
          check("high_cnt", High_Cnt, m.high);
          check("locked_at_valid", Locked, 1);
          pend_cyc = cyc + 1;
          pend_err = m.err;
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int sa;
    bit lvl;
    Rst    = 1'b1;
    Mon_In = 1'b0;
    Clr    = 1'b0;
    reset_dut(3);

    // Toggle every 4 cycles: period 8, high 4.
    for (int i = 0; i < 6; i++) begin
      seg(1'b1, 4);
      seg(1'b0, 4);
    end
    drain();
    check("toggle4_prd_err", Prd_Err, 0);
    check("toggle4_locked", Locked, 1);

    // Period 2 is below MIN_PRD; error stays after returning to period 8.
    for (int i = 0; i < 4; i++) begin
      seg(1'b1, 1);
      seg(1'b0, 1);
    end
    for (int i = 0; i < 3; i++) begin
      seg(1'b1, 4);
      seg(1'b0, 4);
    end
    drain();
    check("short_prd_sticky", Prd_Err, 1);
    do_clr();

    // Clr in the same cycle as an error-setting Prd_Valid: set wins.
    for (int i = 0; i < 2; i++) begin
      seg(1'b1, 4);
      seg(1'b0, 4);
    end
    clr_on_bad = 1'b1;
    seg(1'b1, 1);
    seg(1'b0, 1);
    seg(1'b1, 4);
    seg(1'b0, 4);
    drain();
    check("clr_vs_set", Prd_Err, 1);
    do_clr();

    // Random periods, some beyond MAX_PRD or below MIN_PRD.
    for (int i = 0; i < 40; i++) begin
      lvl = ~mlvl;
      seg(lvl, int'($urandom_range(1, 40)));
    end
    drain();

    // Stuck: hold high for 300 cycles while locked.
    seg(1'b0, 4);
    seg(1'b1, 4);
    seg(1'b0, 4);
    seg(1'b1, 4);
    seg(1'b0, 4);
    drive_cycle(1'b1);
    sa = mlast_chg + 2 + int'(STUCK_LIM);
    for (int i = 1; i < 300; i++) begin
      drive_cycle(1'b1);
      if (cyc == sa - 1) begin
        check("stuck_before_lim", Stuck, 0);
        check("locked_before_lim", Locked, 1);
      end
      if (cyc == sa) begin
        check("stuck_at_lim", Stuck, 1);
        check("unlocked_at_lim", Locked, 0);
      end
    end
    check("stuck_held", Stuck, 1);
    seg(1'b0, 4);
    check("stuck_cleared", Stuck, 0);
    seg(1'b1, 4);
    check("armed_after_stuck", Locked, 0);
    seg(1'b0, 4);
    seg(1'b1, 4);
    seg(1'b0, 4);
    drain();
    check("relocked_after_stuck", Locked, 1);

    // Reset mid-period after lock.
    seg(1'b1, 4);
    seg(1'b0, 4);
    seg(1'b1, 4);
    seg(1'b0, 2);
    drain();
    reset_dut(1);
    seg(1'b0, 3);
    seg(1'b1, 4);
    seg(1'b0, 4);
    check("armed_after_reset", Locked, 0);
    seg(1'b1, 4);
    seg(1'b0, 4);

    // Narrow 1-cycle-high pulse every 8 cycles.
    for (int i = 0; i < 4; i++) begin
      seg(1'b1, 1);
      seg(1'b0, 7);
    end
    drain();
    check("duty_prd_err", Prd_Err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of all cycle counters and measurement outputs.
REQ-002 SHALL have parameter MIN_PRD, default 4, smallest legal measured period in Clk cycles.
REQ-003 SHALL have parameter MAX_PRD, default 64, largest legal measured period in Clk cycles.
REQ-004 SHALL have parameter STUCK_LIM, default 256, the number of consecutive edge-free Clk cycles that declares the monitored signal stuck.
REQ-005 SHALL have port Clk  input  1  the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port Rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port Mon_In  input  1  the monitored clock-like signal, asynchronous to Clk.
REQ-008 SHALL have port Clr  input  1  single-cycle clear for the sticky Prd_Err flag.
REQ-009 SHALL have port Prd_Valid  output  1  one-cycle pulse marking a new measurement.
REQ-010 SHALL have port Prd_Cnt  output  CNT_W  the last measured period in Clk cycles.
REQ-011 SHALL have port High_Cnt  output  CNT_W  the last measured high time in Clk cycles.
REQ-012 SHALL have port Locked  output  1  asserted once at least one full period has been measured.
REQ-013 SHALL have port Stuck  output  1  asserted while no Mon_In edge has occurred for STUCK_LIM cycles.
REQ-014 SHALL have port Prd_Err  output  1  sticky flag set by an out-of-range period.

Function
REQ-015 SHALL pass Mon_In through two flops (s1, s2), then a third flop s3; rise = s2 & ~s3; fall = ~s2 & s3.
REQ-016 SHALL run cycle counter cnt, loaded with 1 on rise and incremented otherwise, saturating at 2^CNT_W-1 (no wrap).
REQ-017 SHALL run high counter hcnt, loaded with 1 on rise, incremented while s2=1, and frozen while s2=0, saturating like cnt.
REQ-018 SHALL implement the states IDLE, ARMED and LOCK.
REQ-019 SHALL move IDLE->ARMED on rise.
REQ-020 SHALL move ARMED->LOCK on the next rise.
REQ-021 SHALL move any state->IDLE when the edge-free count reaches STUCK_LIM.
REQ-022 SHALL, on rise in ARMED or LOCK, register Prd_Cnt<=cnt and High_Cnt<=hcnt and pulse Prd_Valid for exactly one cycle, with all three visible in the cycle after rise is detected.
REQ-023 SHALL produce no Prd_Valid on the first rise after IDLE, because the measurement would be partial.
REQ-024 SHALL give a latency of 3 Clk edges from the first edge sampling Mon_In high to Prd_Valid=1.
REQ-025 SHALL drive Locked=1 exactly when state==LOCK.
REQ-026 SHALL count consecutive cycles with neither rise nor fall in an idle counter, which saturates at STUCK_LIM; Stuck SHALL be 1 when that counter equals STUCK_LIM, and the first subsequent edge SHALL clear Stuck and the counter.
REQ-027 SHALL set Prd_Err when Prd_Valid fires with Prd_Cnt<MIN_PRD or Prd_Cnt>MAX_PRD; Prd_Err SHALL hold until Clr or Rst.
REQ-028 SHALL let set win over Clr when Clr coincides with an error-setting Prd_Valid, leaving Prd_Err=1.
REQ-029 SHALL treat a saturated cnt as out of range and keep its value frozen at the maximum.

Reset
REQ-030 SHALL, on Rst=1 at a Clk edge, clear s1/s2/s3, cnt, hcnt and the idle counter, force IDLE, and zero Prd_Valid, Prd_Cnt, High_Cnt, Locked, Stuck and Prd_Err.
REQ-031 SHALL let Rst abort a measurement in progress, discarding partial counts, with no Prd_Valid for that period.
REQ-032 SHALL give Rst priority over Clr and all edge events.

Configuration
REQ-033 SHALL, with CLK_MON_DUTY_EN defined, implement hcnt and High_Cnt per REQ-017/022, and also set Prd_Err on a valid measurement where High_Cnt==0 or High_Cnt==Prd_Cnt.
REQ-034 SHALL, with CLK_MON_DUTY_EN undefined, omit hcnt, tie High_Cnt to 0, and perform no duty check.

Verification
REQ-035 SHALL cover: Mon_In toggling every 4 Clk cycles -> second and later rises give Prd_Valid with Prd_Cnt=8, High_Cnt=4, Locked=1, Prd_Err=0.
REQ-036 SHALL cover: Mon_In period 2 cycles (MIN_PRD=4) -> Prd_Cnt=2 and Prd_Err=1; Prd_Err stays 1 after Mon_In returns to period 8; Clr clears it.
REQ-037 SHALL cover: Mon_In held at 1 for 300 cycles while locked -> Stuck=1 exactly STUCK_LIM=256 cycles after the last edge, state IDLE, Locked=0; the next edge clears Stuck, with no Prd_Valid until two rises.
REQ-038 SHALL cover: Rst asserted mid-period after lock -> all outputs 0 the next cycle, and the first post-reset rise produces no Prd_Valid.
REQ-039 SHALL cover: Clr asserted in the same cycle as an out-of-range Prd_Valid -> Prd_Err=1.
REQ-040 SHALL cover: with CLK_MON_DUTY_EN, a 1-cycle-high pulse every 8 cycles -> High_Cnt=1 and Prd_Err=0; without the macro -> High_Cnt=0 always.
